// File: rtl/seq_frame_pkg.sv
// seq_frame_pkg: shared state encoding and frame word layout
// for the seq_frame_ctrl table sequencer
package seq_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PHASE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int FRAME_WORDS = 2;

  localparam int REP_LSB  = 16;
  localparam int REP_W    = 16;
  localparam int MASK_LSB = 12;
  localparam int MASK_W   = 4;
  localparam int VAL_LSB  = 8;
  localparam int VAL_W    = 4;
  localparam int OUT_LSB  = 0;
  localparam int OUT_W    = 6;

  function automatic logic [REP_W-1:0] f_rep(
    input logic [31:0] w
  );
    return w[REP_LSB +: REP_W];
  endfunction

  function automatic logic [MASK_W-1:0] f_mask(
    input logic [31:0] w
  );
    return w[MASK_LSB +: MASK_W];
  endfunction

  function automatic logic [VAL_W-1:0] f_val(
    input logic [31:0] w
  );
    return w[VAL_LSB +: VAL_W];
  endfunction

  function automatic logic [OUT_W-1:0] f_out(
    input logic [31:0] w
  );
    return w[OUT_LSB +: OUT_W];
  endfunction

endpackage

// File: rtl/seq_table_ram.sv
// seq_table_ram: simple dual-port frame table memory
// one write port, one registered read port (1-cycle latency)
module seq_table_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // write port; contents are never cleared
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/seq_frame_ctrl.sv
// seq_frame_ctrl: table-driven frame sequencer with prescaled ticks
// trigger matching built only with SEQ_FRAME_CTRL_TRIG_EN defined
module seq_frame_ctrl #(
  parameter int DEPTH = 512
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        trst_i,
  input  logic        tdat_wstb_i,
  input  logic [31:0] tdat_i,
  input  logic [15:0] tlen_i,
  input  logic [31:0] presc_i,
  input  logic [15:0] trepeat_i,
  input  logic        gate_i,
  input  logic [3:0]  inp_i,
  output logic [5:0]  out_o,
  output logic        active_o,
  output logic [15:0] cur_frame_o,
  output logic [15:0] cur_fcycle_o,
  output logic [15:0] cur_tcycle_o,
  output logic [2:0]  state_o,
  output logic        err_o
);

  import seq_frame_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] WP_FULL = PW'(DEPTH);

  state_t state, state_n;
  logic gate_q, gate_rise;

  logic [PW-1:0] wptr;
  logic err;
  logic ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr, base;
  logic [31:0] ram_rdata;

  logic [1:0]  lcnt;
  logic [31:0] w0, w1;
  logic [15:0] fidx, cur_frame;
  logic [15:0] cur_fcycle, cur_tcycle;
  logic [31:0] pcnt, tcnt;
  logic [5:0]  out_q;

  logic [31:0] pmax, tmax;
  logic [15:0] rmax;
  logic trig_ok, tick, last_tick;
  logic last_frame, fr_more, t_done;
  logic start, ld_done, go;
  logic again, adv, wrap;

  // a write coinciding with a table reset lands at word 0
  assign ram_we    = tdat_wstb_i &&
                     (trst_i || (wptr != WP_FULL));
  assign ram_waddr = trst_i ? '0 : wptr[AW-1:0];

  assign base      = AW'(32'(fidx) * FRAME_WORDS);
  assign ram_raddr = base + AW'(lcnt[0]);

  seq_table_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (tdat_i),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign gate_rise = gate_i && !gate_q;

  assign pmax = (presc_i == 32'd0) ? 32'd1 : presc_i;
  assign tmax = (w1 == 32'd0) ? 32'd1 : w1;
  assign rmax = (f_rep(w0) == 16'd0) ?
                16'd1 : f_rep(w0);

  assign tick      = (state == ST_PHASE) &&
                     (pcnt == pmax - 32'd1);
  assign last_tick = (tcnt == tmax - 32'd1);
  assign fr_more   = (cur_fcycle < rmax);
  assign last_frame = ({1'b0, fidx} + 17'd1) >=
                      {1'b0, tlen_i};
  assign t_done    = (trepeat_i != 16'd0) &&
                     (cur_tcycle >= trepeat_i);

`ifdef SEQ_FRAME_CTRL_TRIG_EN
  logic unused_trig;
  assign unused_trig = ^w0[7:6];
  assign trig_ok = ((inp_i ^ f_val(w0)) &
                    f_mask(w0)) == 4'h0;
`else
  logic unused_trig;
  assign unused_trig = ^{inp_i, w0[15:6]};
  assign trig_ok = 1'b1;
`endif

  // write pointer and sticky overflow flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      err  <= 1'b0;
    end else if (trst_i) begin
      wptr <= tdat_wstb_i ? PW'(1) : '0;
      err  <= 1'b0;
    end else if (tdat_wstb_i) begin
      if (wptr == WP_FULL) err <= 1'b1;
      else wptr <= wptr + PW'(1);
    end
  end

  // state register and gate edge history
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= ST_IDLE;
      gate_q <= 1'b0;
    end else begin
      state  <= state_n;
      gate_q <= gate_i;
    end
  end

  // next state and one-cycle sequencing strobes
  always_comb begin
    state_n = state;
    start   = 1'b0;
    ld_done = 1'b0;
    go      = 1'b0;
    again   = 1'b0;
    adv     = 1'b0;
    wrap    = 1'b0;
    if (!gate_i) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (gate_rise && tlen_i != 16'd0) begin
            state_n = ST_LOAD;
            start   = 1'b1;
          end
        end
        ST_LOAD: begin
          if (lcnt == 2'd2) begin
            state_n = ST_WAIT;
            ld_done = 1'b1;
          end
        end
        ST_WAIT: begin
          if (trig_ok) begin
            state_n = ST_PHASE;
            go      = 1'b1;
          end
        end
        ST_PHASE: begin
          if (tick && last_tick) begin
            if (fr_more) begin
              state_n = ST_WAIT;
              again   = 1'b1;
            end else if (!last_frame) begin
              state_n = ST_LOAD;
              adv     = 1'b1;
            end else if (t_done) begin
              state_n = ST_DONE;
            end else begin
              state_n = ST_LOAD;
              wrap    = 1'b1;
            end
          end
        end
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // frame words, counters, prescaler and output register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lcnt       <= 2'd0;
      w0         <= '0;
      w1         <= '0;
      fidx       <= '0;
      cur_frame  <= '0;
      cur_fcycle <= '0;
      cur_tcycle <= '0;
      pcnt       <= '0;
      tcnt       <= '0;
      out_q      <= '0;
    end else begin
      lcnt <= (state == ST_LOAD) ?
              lcnt + 2'd1 : 2'd0;
      if (state == ST_LOAD && lcnt == 2'd1)
        w0 <= ram_rdata;
      if (state == ST_LOAD && lcnt == 2'd2)
        w1 <= ram_rdata;
      if (start) begin
        fidx       <= '0;
        cur_frame  <= '0;
        cur_fcycle <= '0;
        cur_tcycle <= '0;
      end
      if (ld_done) begin
        cur_frame  <= fidx + 16'd1;
        cur_fcycle <= 16'd1;
        if (cur_tcycle == 16'd0)
          cur_tcycle <= 16'd1;
      end
      if (again)
        cur_fcycle <= cur_fcycle + 16'd1;
      if (adv)
        fidx <= fidx + 16'd1;
      if (wrap) begin
        fidx <= '0;
        if (cur_tcycle != 16'hFFFF)
          cur_tcycle <= cur_tcycle + 16'd1;
      end
      if (go) begin
        pcnt <= '0;
        tcnt <= '0;
      end else if (state == ST_PHASE) begin
        if (tick) begin
          pcnt <= '0;
          tcnt <= tcnt + 32'd1;
        end else begin
          pcnt <= pcnt + 32'd1;
        end
      end
      if (go)
        out_q <= f_out(w0);
      if (state_n == ST_IDLE || state_n == ST_DONE)
        out_q <= '0;
    end
  end

  assign out_o        = out_q;
  assign active_o     = (state != ST_IDLE);
  assign state_o      = state;
  assign cur_frame_o  = cur_frame;
  assign cur_fcycle_o = cur_fcycle;
  assign cur_tcycle_o = cur_tcycle;
  assign err_o        = err;

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// tb_seq_frame_ctrl: self-checking bench for seq_frame_ctrl
// per-cycle trace model built from the frame table plus directed checks
module tb_seq_frame_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trst;
  logic        wstb;
  logic [31:0] tdat;
  logic [15:0] tlen;
  logic [31:0] presc;
  logic [15:0] trep;
  logic        gate;
  logic [3:0]  inp;
  logic [5:0]  out;
  logic        active;
  logic [15:0] cur_frame, cur_fcycle, cur_tcycle;
  logic [2:0]  state;
  logic        err;

  always #5 clk = ~clk;

  seq_frame_ctrl #(
    .DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .trst_i       (trst),
    .tdat_wstb_i  (wstb),
    .tdat_i       (tdat),
    .tlen_i       (tlen),
    .presc_i      (presc),
    .trepeat_i    (trep),
    .gate_i       (gate),
    .inp_i        (inp),
    .out_o        (out),
    .active_o     (active),
    .cur_frame_o  (cur_frame),
    .cur_fcycle_o (cur_fcycle),
    .cur_tcycle_o (cur_tcycle),
    .state_o      (state),
    .err_o        (err)
  );

  typedef struct {
    int st;
    int out;
    int fr;
    int fc;
    int tc;
  } exp_t;

  exp_t q[$];
  bit model_on = 1'b0;
  int nchk = 0;
  int npass = 0;
  logic [31:0] fw0 [4];
  logic [31:0] fw1 [4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  function automatic void push(int st, int o,
                               int fr, int fc, int tc);
    exp_t e;
    e.st = st;
    e.out = o;
    e.fr = fr;
    e.fc = fc;
    e.tc = tc;
    q.push_back(e);
  endfunction

  // expected cycle trace of a full run from the gate edge
  task automatic build(input int tl, input int pr,
                       input int trp, input int passes);
    int p;
    int np;
    int last;
    p = (pr == 0) ? 1 : pr;
    np = (trp == 0) ? passes : trp;
    last = 0;
    q.delete();
    for (int t = 1; t <= np; t++) begin
      for (int f = 0; f < tl; f++) begin
        int rep;
        int tm;
        int o;
        rep = int'(fw0[f][31:16]);
        tm = int'(fw1[f]);
        o = int'(fw0[f][5:0]);
        if (rep == 0) rep = 1;
        if (tm == 0) tm = 1;
        repeat (3) push(1, last, 0, 0, 0);
        for (int r = 1; r <= rep; r++) begin
          push(2, last, 0, 0, 0);
          repeat (tm * p) push(3, o, f + 1, r, t);
          last = o;
        end
      end
    end
  endtask

  // compare the DUT against the trace every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (model_on) begin
        if (q.size() > 0) e = q.pop_front();
        else e = '{st:4, out:0, fr:0, fc:0, tc:0};
        chk("cyc_state", 32'(state), e.st);
        chk("cyc_out", 32'(out), e.out);
        chk("cyc_active", 32'(active),
            32'(e.st != 0));
        if (e.st == 3) begin
          chk("cyc_frame", 32'(cur_frame), e.fr);
          chk("cyc_fcycle", 32'(cur_fcycle), e.fc);
          chk("cyc_tcycle", 32'(cur_tcycle), e.tc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] w);
    tdat = w;
    wstb = 1'b1;
    step(1);
    wstb = 1'b0;
  endtask

  task automatic load_table(input int n, input bit rst_ptr);
    for (int i = 0; i < n; i++) begin
      if (i == 0 && rst_ptr) trst = 1'b1;
      wr(fw0[i]);
      trst = 1'b0;
      wr(fw1[i]);
    end
  endtask

  task automatic start_run();
    gate = 1'b0;
    step(1);
    gate = 1'b1;
    step(1);
    model_on = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_state"}, 32'(state), 0);
    chk({nm, "_out"}, 32'(out), 0);
    chk({nm, "_active"}, 32'(active), 0);
    chk({nm, "_frame"}, 32'(cur_frame), 0);
    chk({nm, "_fcycle"}, 32'(cur_fcycle), 0);
    chk({nm, "_tcycle"}, 32'(cur_tcycle), 0);
    chk({nm, "_err"}, 32'(err), 0);
  endtask

  initial begin
    int pat [10] = '{1, 1, 1, 2, 2, 1, 1, 1, 2, 2};
    int idx;
    int k;
    rst_n = 1'b0;
    trst = 1'b0;
    wstb = 1'b0;
    tdat = '0;
    tlen = '0;
    presc = '0;
    trep = '0;
    gate = 1'b0;
    inp = '0;
    step(2);
    chk_zero("reset");
    rst_n = 1'b1;
    step(1);

    // table overflow, then pointer reset
    trst = 1'b1;
    step(1);
    trst = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      wr(i[0] ? 32'h0000_0002 : 32'h0000_003F);
    chk("ovf_err_before", 32'(err), 0);
    wr(32'hDEAD_BEEF);
    chk("ovf_err_set", 32'(err), 1);
    trst = 1'b1;
    step(1);
    trst = 1'b0;
    chk("ovf_err_clr", 32'(err), 0);

    // single frame, prescaled, one table pass
    fw0[0] = 32'h0001_0015;
    fw1[0] = 32'd4;
    load_table(1, 1'b0);
    tlen = 16'd1;
    presc = 32'd2;
    trep = 16'd1;
    build(1, 2, 1, 1);
    chk("model041_len", q.size(), 12);
    idx = 0;
    foreach (q[i]) if (q[i].out == 'h15) idx++;
    chk("model041_hi", idx, 8);
    start_run();
    step(14);
    model_on = 1'b0;
    chk("r041_done", 32'(state), 4);
    chk("r041_out", 32'(out), 0);
    chk("r041_tcyc", 32'(cur_tcycle), 1);
    gate = 1'b0;
    step(1);
    chk("r041_idle", 32'(state), 0);

    // two frames with frame repeats, two table passes
    fw0[0] = 32'h0003_0001;
    fw1[0] = 32'd1;
    fw0[1] = 32'h0001_0002;
    fw1[1] = 32'd2;
    load_table(2, 1'b1);
    tlen = 16'd2;
    presc = 32'd1;
    trep = 16'd2;
    build(2, 1, 2, 1);
    chk("model042_len", q.size(), 30);
    idx = 0;
    foreach (q[i]) begin
      if (q[i].st == 3) begin
        if (idx < 10)
          chk("model042_pat", q[i].out, pat[idx]);
        idx++;
      end
    end
    chk("model042_nph", idx, 10);
    start_run();
    step(33);
    model_on = 1'b0;
    chk("r042_done", 32'(state), 4);
    chk("r042_tcyc", 32'(cur_tcycle), 2);

    // gate drop in frame 2, then restart at frame 1
    trep = 16'd0;
    build(2, 1, 0, 2);
    k = -1;
    foreach (q[i])
      if (k < 0 && q[i].st == 3 && q[i].fr == 2) k = i;
    chk("model044_k", k, 13);
    start_run();
    step(k + 1);
    model_on = 1'b0;
    gate = 1'b0;
    step(1);
    chk("drop_state", 32'(state), 0);
    chk("drop_out", 32'(out), 0);
    chk("drop_active", 32'(active), 0);
    chk("drop_frame", 32'(cur_frame), 2);
    step(2);
    chk("drop_hold", 32'(cur_frame), 2);
    build(2, 1, 0, 2);
    start_run();
    chk("restart_frame", 32'(cur_frame), 0);
    chk("restart_fcyc", 32'(cur_fcycle), 0);
    chk("restart_tcyc", 32'(cur_tcycle), 0);
    step(16);
    model_on = 1'b0;
    gate = 1'b0;
    step(2);

    // trigger wait on input A
    fw0[0] = 32'h0001_112A;
    fw1[0] = 32'd1;
    load_table(1, 1'b1);
    tlen = 16'd1;
    presc = 32'd1;
    trep = 16'd1;
    inp = 4'h0;
    gate = 1'b0;
    step(1);
    gate = 1'b1;
    step(4);
`ifdef SEQ_FRAME_CTRL_TRIG_EN
    for (int i = 0; i < 50; i++) begin
      chk("trig_wait", 32'(state), 2);
      chk("trig_wait_out", 32'(out), 0);
      if (i < 49) step(1);
    end
    inp = 4'h1;
    chk("trig_edge_out", 32'(out), 0);
    step(1);
    chk("trig_phase", 32'(state), 3);
    chk("trig_out", 32'(out), 'h2A);
`else
    chk("notrig_wait", 32'(state), 2);
    step(1);
    chk("notrig_phase", 32'(state), 3);
    chk("notrig_out", 32'(out), 'h2A);
`endif
    step(1);
    chk("trig_done", 32'(state), 4);
    chk("trig_done_out", 32'(out), 0);
    gate = 1'b0;
    inp = 4'h0;
    step(2);

    // reset mid-phase, table must survive
    fw0[0] = 32'h0001_0015;
    fw1[0] = 32'd4;
    load_table(1, 1'b1);
    tlen = 16'd1;
    presc = 32'd2;
    trep = 16'd1;
    build(1, 2, 1, 1);
    start_run();
    step(6);
    model_on = 1'b0;
    chk("rst_in_phase", 32'(state), 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    gate = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
    build(1, 2, 1, 1);
    start_run();
    step(14);
    model_on = 1'b0;
    chk("rerun_done", 32'(state), 4);
    chk("rerun_tcyc", 32'(cur_tcycle), 1);
    chk("rerun_out", 32'(out), 0);
    gate = 1'b0;
    step(1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
